// File: rtl/dance_ctrl.sv
// Input conditioning and pacing for the LED pattern engine: synchronizes and
// debounces the slide switches, decodes run/mode/speed and emits a paced step strobe.
module dance_ctrl #(
   parameter int DEB_CYCLES = 1000000,
   parameter int SLOW_DIV   = 67108864,
   parameter int FAST_DIV   = 16777216,
   parameter int CNT_W      = 26
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic [3:0] SW,
   output logic       step,
   output logic [1:0] mode,
   output logic       mode_chg,
   output logic       running
);

   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
   localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

   localparam logic [1:0] MODE_LEFT  = 2'd0;
   localparam logic [1:0] MODE_RIGHT = 2'd1;
   localparam logic [1:0] MODE_INV   = 2'd2;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   logic [3:0]       sw_meta_q,   sw_meta_d;
   logic [3:0]       sw_sync_q,   sw_sync_d;
   logic [3:0]       sw_stable_q, sw_stable_d;
   logic [DEB_W-1:0] deb_cnt_q [4];
   logic [DEB_W-1:0] deb_cnt_d [4];
   state_t           state_q,     state_d;
   logic [CNT_W-1:0] presc_q,     presc_d;
   logic             step_q,      step_d;
   logic [1:0]       mode_q,      mode_d;
   logic             mode_chg_q,  mode_chg_d;

   logic [1:0]       next_mode;
   logic [CNT_W-1:0] div_last;

   // A bit is accepted only after its synchronized value has differed from
   // the stable value for DEB_CYCLES consecutive cycles.
   always_comb begin
      sw_meta_d   = SW;
      sw_sync_d   = sw_meta_q;
      sw_stable_d = sw_stable_q;
      for (int i = 0; i < 4; i++) begin
         deb_cnt_d[i] = '0;
         if (sw_sync_q[i] != sw_stable_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) begin
               sw_stable_d[i] = sw_sync_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
         end
      end
   end

   always_comb begin
      next_mode = sw_stable_q[2] ? MODE_INV : (sw_stable_q[1] ? MODE_RIGHT : MODE_LEFT);
      div_last  = sw_stable_q[3] ? FAST_LAST : SLOW_LAST;
   end

   // Using >= lets a slow-to-fast change mid-period fire on the next cycle
   // instead of waiting for a prescaler wrap.
   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      step_d     = 1'b0;
      mode_d     = mode_q;
      mode_chg_d = 1'b0;
      case (state_q)
         IDLE: begin
            presc_d = '0;
            if (sw_stable_q[0]) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!sw_stable_q[0]) begin
               state_d = IDLE;
               presc_d = '0;
            end else if (presc_q >= div_last) begin
               presc_d    = '0;
               step_d     = 1'b1;
               mode_d     = next_mode;
               mode_chg_d = (next_mode != mode_q);
            end else begin
               presc_d = presc_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            presc_d = '0;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         sw_meta_q   <= '0;
         sw_sync_q   <= '0;
         sw_stable_q <= '0;
         for (int i = 0; i < 4; i++) begin
            deb_cnt_q[i] <= '0;
         end
         state_q    <= IDLE;
         presc_q    <= '0;
         step_q     <= 1'b0;
         mode_q     <= MODE_LEFT;
         mode_chg_q <= 1'b0;
      end else begin
         sw_meta_q   <= sw_meta_d;
         sw_sync_q   <= sw_sync_d;
         sw_stable_q <= sw_stable_d;
         for (int i = 0; i < 4; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
         end
         state_q    <= state_d;
         presc_q    <= presc_d;
         step_q     <= step_d;
         mode_q     <= mode_d;
         mode_chg_q <= mode_chg_d;
      end
   end

   assign step     = step_q;
   assign mode     = mode_q;
   assign mode_chg = mode_chg_q;
   assign running  = (state_q == RUN);

endmodule

// File: tb/tb_dance_ctrl.sv
// Directed bench for dance_ctrl with DEB_CYCLES=4, SLOW_DIV=8, FAST_DIV=2;
// every cycle is checked against hand-computed step/mode/mode_chg/running values.
module tb_dance_ctrl;

   logic       Clock;
   logic       Resetn;
   logic [3:0] SW;
   logic       step;
   logic [1:0] mode;
   logic       mode_chg;
   logic       running;

   int testsRun = 0;
   int testsFailed = 0;
   int cycle = 0;

   typedef struct {
      logic [3:0] sw;
      logic       rstn;
      logic       expStep;
      logic [1:0] expMode;
      logic       expChg;
      logic       expRun;
      string      name;
   } vec_t;

   vec_t vecs[$];

   dance_ctrl #(
      .DEB_CYCLES(4),
      .SLOW_DIV(8),
      .FAST_DIV(2),
      .CNT_W(4)
   ) dut (
      .Clock(Clock),
      .Resetn(Resetn),
      .SW(SW),
      .step(step),
      .mode(mode),
      .mode_chg(mode_chg),
      .running(running)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
      $fatal(1, "[TB] watchdog");
   end

   function automatic void add(int n, logic [3:0] sw, logic rstn, logic s,
                               logic [1:0] m, logic c, logic r, string name);
      for (int i = 0; i < n; i++) begin
         vecs.push_back('{sw: sw, rstn: rstn, expStep: s, expMode: m,
                          expChg: c, expRun: r, name: name});
      end
   endfunction

   // Inputs change 1 time unit after a rising edge, are taken at the next
   // edge, and the outputs are sampled 1 time unit after that edge.
   task automatic applyStimulus(input logic [3:0] sw, input logic rstn);
      SW = sw;
      Resetn = rstn;
      @(posedge Clock);
      #1;
      cycle++;
   endtask

   task automatic checkOutput(input string name, input logic s, input logic [1:0] m,
                              input logic c, input logic r);
      testsRun++;
      if (step !== s) begin
         testsFailed++;
         $display("[TB] FAIL %s cyc %0d step got %0b want %0b", name, cycle, step, s);
      end
      testsRun++;
      if (mode !== m) begin
         testsFailed++;
         $display("[TB] FAIL %s cyc %0d mode got %0d want %0d", name, cycle, mode, m);
      end
      testsRun++;
      if (mode_chg !== c) begin
         testsFailed++;
         $display("[TB] FAIL %s cyc %0d mode_chg got %0b want %0b", name, cycle, mode_chg, c);
      end
      testsRun++;
      if (running !== r) begin
         testsFailed++;
         $display("[TB] FAIL %s cyc %0d running got %0b want %0b", name, cycle, running, r);
      end
   endtask

   task automatic runSeq(input string name, input int n, input logic [3:0] sw,
                         input logic rstn, input logic s, input logic [1:0] m,
                         input logic c, input logic r);
      for (int i = 0; i < n; i++) begin
         applyStimulus(sw, rstn);
         checkOutput(name, s, m, c, r);
      end
   endtask

   initial begin
      SW = 4'h0;
      Resetn = 1'b0;
      @(posedge Clock);
      #1;

      // Reset, startup latency, slow pacing and two mode changes.
      add(3, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "reset");
      add(6, 4'h1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "sync_deb");
      add(8, 4'h1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, "run_wait");
      add(1, 4'h1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, "first_step");
      add(7, 4'h1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, "slow_gap");
      add(1, 4'h1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, "second_step");
      add(1, 4'h1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, "after_step");
      add(6, 4'h3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, "right_pending");
      add(1, 4'h3, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, "right_step");
      add(1, 4'h3, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, "right_hold");
      add(6, 4'h7, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, "inv_pending");
      add(1, 4'h7, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, "inv_step");
      add(7, 4'h7, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, "inv_gap");
      add(1, 4'h7, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, "same_mode_step");

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].sw, vecs[i].rstn);
         checkOutput(vecs[i].name, vecs[i].expStep, vecs[i].expMode,
                     vecs[i].expChg, vecs[i].expRun);
      end

      // Slow to fast mid-period: prescaler is already past FAST_DIV-1.
      runSeq("spd_deb", 6, 4'hF, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
      runSeq("spd_first", 1, 4'hF, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         runSeq("fast_gap", 1, 4'hF, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
         runSeq("fast_step", 1, 4'hF, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
      end

      // Fast steps continue until the cleared speed bit is debounced.
      for (int i = 0; i < 3; i++) begin
         runSeq("fast_tail_gap", 1, 4'h7, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
         runSeq("fast_tail_step", 1, 4'h7, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
      end
      for (int i = 0; i < 2; i++) begin
         runSeq("slow_again_gap", 7, 4'h7, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
         runSeq("slow_again_step", 1, 4'h7, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
      end

      // Run drops exactly when the step would otherwise fire.
      runSeq("pre_stop", 1, 4'h7, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
      runSeq("stop_deb", 6, 4'h6, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
      runSeq("stop_edge", 1, 4'h6, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
      runSeq("idle_hold", 3, 4'h6, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);

      // Run bounce: 3 high / 2 low never survives a 4-cycle debounce.
      for (int i = 0; i < 5; i++) begin
         runSeq("bounce_hi", 3, 4'h7, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
         runSeq("bounce_lo", 2, 4'h6, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
      end
      runSeq("hold_deb", 6, 4'h7, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
      runSeq("hold_run", 8, 4'h7, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
      runSeq("hold_step", 1, 4'h7, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
      runSeq("hold_after", 2, 4'h7, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);

      // One-cycle reset mid-run clears mode and restarts the startup latency.
      runSeq("midrun_reset", 1, 4'h1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      runSeq("rst_deb", 6, 4'h1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      runSeq("rst_run", 8, 4'h1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
      runSeq("rst_step", 1, 4'h1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
      runSeq("rst_after", 1, 4'h1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
